// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled serial receiver with a small byte FIFO.
// Deframes 8N1 bytes (LSB first) from an asynchronous rx line, buffers them
// and presents them on a valid/ready interface. Frame errors and dropped
// bytes are reported as one-cycle pulses.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds a
// PARITY state plus even-parity checking; without it no parity logic exists.
module uart_rx_fifo #(
  parameter int SYS_CLK_FREQ   = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  input  logic       rx_ready_in,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       frame_err_out,
  output logic       overflow_out
);

  localparam int DIV   = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam logic [DIV_W-1:0]        DIV_MAX  = DIV_W'(DIV - 1);
  localparam logic [FIFO_DEPTH_LOG:0] DEPTH_CT = (FIFO_DEPTH_LOG + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer: resets to the idle (high) line level
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q, sync_d;
  logic       rxs;

  // Next value of the two-stage synchronizer chain
  always_comb begin
    sync_d = {sync_q[0], rx_in};
  end

  // Synchronizer flops
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

  assign rxs = sync_q[1];

  // ---------------------------------------------------------------------------
  // FSM-side registers (declared early; the tick generator needs the state)
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] tick_idx_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       s7_q, s8_q;
  logic       sample_q;
  logic       samp_vld_q;
  logic       frame_err_q;
  logic       overflow_q;
`ifdef UART_RX_PARITY_EN
  logic       parity_q;
`endif

  // ---------------------------------------------------------------------------
  // Tick generator: 16 ticks per bit, realigned to the start edge
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  logic             start_go;

  assign tick     = (div_cnt_q == DIV_MAX);
  assign start_go = (state_q == S_IDLE) && !rxs;

  // Divider next-state: wrap on tick, restart when a frame begins
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (start_go || tick) div_cnt_d = '0;
  end

  // Divider counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // STOP decision and FIFO handshake
  // ---------------------------------------------------------------------------
  logic                      stop_decide;
  logic                      par_ok;
  logic                      push_req;
  logic                      push_ok;
  logic                      pop;
  logic                      full;
  logic [FIFO_DEPTH_LOG:0]   count_q, count_d;
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic                      maj;

  assign maj = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);

  // Decide whether the finished byte is pushed this cycle
  always_comb begin
    stop_decide = (state_q == S_STOP) && samp_vld_q;
`ifdef UART_RX_PARITY_EN
    par_ok      = ~(^shift_q ^ parity_q);
`else
    par_ok      = 1'b1;
`endif
    pop         = rx_valid_out && rx_ready_in;
    full        = (count_q == DEPTH_CT);
    push_req    = stop_decide && sample_q && par_ok;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok     = push_req && (!full || pop);
  end

  // ---------------------------------------------------------------------------
  // Receive FSM with registered sampling and error pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      tick_idx_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      sample_q    <= 1'b1;
      samp_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      samp_vld_q  <= 1'b0;

      // Bit-cell timing: majority of ticks 7/8/9, registered at tick 9
      if (state_q != S_IDLE && tick) begin
        tick_idx_q <= tick_idx_q + 4'd1;
        if (tick_idx_q == 4'd7) s7_q <= rxs;
        if (tick_idx_q == 4'd8) s8_q <= rxs;
        if (tick_idx_q == 4'd9) begin
          sample_q   <= maj;
          samp_vld_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q    <= S_START;
            tick_idx_q <= 4'd0;
          end
        end
        S_START: begin
          if (tick && tick_idx_q == 4'd15) begin
            bit_cnt_q <= 3'd0;
            state_q   <= sample_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick && tick_idx_q == 4'd15) begin
            shift_q[bit_cnt_q] <= sample_q;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick && tick_idx_q == 4'd15) begin
            parity_q <= sample_q;
            state_q  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Leave mid-bit so a directly following start edge is not missed
          if (samp_vld_q) begin
            if (sample_q) begin
              state_q <= S_IDLE;
              if (par_ok) overflow_q  <= !push_ok;
              else        frame_err_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frame_err_out = frame_err_q;
  assign overflow_out  = overflow_q;

  // ---------------------------------------------------------------------------
  // FIFO storage: one resettable register per entry
  // ---------------------------------------------------------------------------
  logic [7:0] mem_rd [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [FIFO_DEPTH_LOG-1:0] ENTRY = FIFO_DEPTH_LOG'(gi);
      logic [7:0] entry_q, entry_d;

      // Capture the received byte when this slot is the write target
      always_comb begin
        entry_d = entry_q;
        if (push_ok && wr_ptr_q == ENTRY) entry_d = shift_q;
      end

      // Entry register
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) entry_q <= 8'd0;
        else        entry_q <= entry_d;
      end

      assign mem_rd[gi] = entry_q;
    end
  endgenerate

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + FIFO_DEPTH_LOG'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + FIFO_DEPTH_LOG'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (FIFO_DEPTH_LOG + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_DEPTH_LOG + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rx_valid_out = (count_q != '0);
  assign rx_data_out  = mem_rd[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo at 16 clocks per bit.
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int DEPTH  = 8;
  localparam int POP_AT = 16 * (NBITS - 1) + 13;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overflow;

  uart_rx_fifo #(
    .SYS_CLK_FREQ  (1600000),
    .BAUD_RATE     (100000),
    .FIFO_DEPTH_LOG(3)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .rx_in        (rx),
    .rx_ready_in  (ready),
    .rx_data_out  (rx_data),
    .rx_valid_out (rx_valid),
    .frame_err_out(frame_err),
    .overflow_out (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int bad_pulse = 0;
  logic fe_prev = 1'b0;
  logic ov_prev = 1'b0;

  logic [7:0] exp_q[$];
  int model_cnt = 0;
  int exp_ovf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts error pulses, flags long or overlapping ones
  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overflow)  ov_cnt <= ov_cnt + 1;
    if ((frame_err && fe_prev) || (overflow && ov_prev) || (frame_err && overflow))
      bad_pulse <= bad_pulse + 1;
    fe_prev <= frame_err;
    ov_prev <= overflow;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_bad;
    repeat (16) @(negedge clk);
`else
    if (par_bad) rx = 1'b1;
`endif
    rx = stop_bit;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] d);
    if (model_cnt < DEPTH) begin
      exp_q.push_back(d);
      model_cnt++;
    end else begin
      exp_ovf++;
    end
    send_frame(d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    logic [7:0] e;
    int w;
    while (exp_q.size() > 0) begin
      w = 0;
      while (!rx_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      e = exp_q.pop_front();
      checks++;
      if (!rx_valid) begin
        failures++;
        $display("FAIL %s: rx_valid_out=0 after wait, expected byte %02h", name, e);
      end else if (rx_data !== e) begin
        failures++;
        $display("FAIL %s: rx_data_out=%02h expected %02h", name, rx_data, e);
      end else begin
        $display("ok   %s: popped %02h", name, rx_data);
      end
      if (rx_valid) begin
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
      model_cnt--;
    end
    model_cnt = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_empty: rx_valid_out=%b expected 0", name, rx_valid);
    end else $display("ok   %s_empty: FIFO empty", name);
  endtask

  task automatic test_reset();
    int valid_seen;
    int fe0;
    int ov0;
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, frame_err, overflow} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs: data=%02h valid=%b fe=%b ov=%b expected all 0",
               rx_data, rx_valid, frame_err, overflow);
    end else $display("ok   reset_outputs");
    rst = 1'b0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    valid_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_valid) valid_seen++;
    end
    checks++;
    if (valid_seen != 0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      failures++;
      $display("FAIL idle_line: valid_cycles=%0d fe=%0d ov=%0d expected 0/0/0",
               valid_seen, fe_cnt - fe0, ov_cnt - ov0);
    end else $display("ok   idle_line: quiet for 200 cycles");
  endtask

  task automatic test_single();
    int s;
    int lat;
    bit seen;
    s = cyc;
    lat = -1;
    seen = 1'b0;
    fork
      send_good(8'hA5);
      begin
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (rx_valid) begin
            seen = 1'b1;
            lat = cyc - s;
          end
        end
      end
    join
    checks++;
    if (lat < 16 * NBITS - 12 || lat > 16 * NBITS + 2) begin
      failures++;
      $display("FAIL single_latency: valid after %0d cycles, expected about %0d",
               lat, 16 * NBITS - 2);
    end else $display("ok   single_latency: %0d cycles", lat);
    idle(10);
    drain("single");
  endtask

  task automatic test_glitch_b2b();
    int fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(60);
    checks++;
    if (rx_valid !== 1'b0 || fe_cnt != fe0) begin
      failures++;
      $display("FAIL glitch: valid=%b fe_pulses=%0d expected 0/0", rx_valid, fe_cnt - fe0);
    end else $display("ok   glitch: rejected");
    send_good(8'h00);
    send_good(8'hFF);
    idle(30);
    drain("b2b");
  endtask

  task automatic test_frame_err();
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(40);
    checks++;
    if (fe_cnt - fe0 != 1 || ov_cnt != ov0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_err: fe_pulses=%0d ov=%0d valid=%b expected 1/0/0",
               fe_cnt - fe0, ov_cnt - ov0, rx_valid);
    end else $display("ok   frame_err: one pulse, FIFO empty");
    send_good(8'h11);
    idle(30);
    drain("after_ferr");
  endtask

  task automatic test_overflow();
    int ov0;
    ov0 = ov_cnt;
    exp_ovf = 0;
    for (int b = 1; b <= 9; b++) send_good(8'(b));
    idle(30);
    checks++;
    if (ov_cnt - ov0 != exp_ovf || exp_ovf != 1) begin
      failures++;
      $display("FAIL overflow: pulses=%0d expected %0d", ov_cnt - ov0, exp_ovf);
    end else $display("ok   overflow: one pulse on byte 9");
    drain("ovf");
  endtask

  task automatic test_full_pop();
    int ov0;
    logic [7:0] e;
    ov0 = ov_cnt;
    for (int b = 1; b <= 8; b++) send_good(8'(b));
    exp_q.push_back(8'h09);
    fork
      send_frame(8'h09, 1'b1, 1'b0);
      begin
        repeat (POP_AT) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== e) begin
          failures++;
          $display("FAIL full_pop_head: valid=%b data=%02h expected 1/%02h", rx_valid, rx_data, e);
        end else $display("ok   full_pop_head: popped %02h with push", rx_data);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    idle(30);
    checks++;
    if (ov_cnt != ov0) begin
      failures++;
      $display("FAIL full_pop_ovf: pulses=%0d expected 0", ov_cnt - ov0);
    end else $display("ok   full_pop_ovf: no overflow");
    drain("full_pop");
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int fe0;
    send_good(8'h07);
    idle(30);
    drain("parity_good");
    fe0 = fe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(40);
    checks++;
    if (fe_cnt - fe0 != 1 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL parity_bad: fe_pulses=%0d valid=%b expected 1/0", fe_cnt - fe0, rx_valid);
    end else $display("ok   parity_bad: rejected");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch_b2b();
    test_frame_err();
    test_overflow();
    test_full_pop();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    @(negedge clk);
    checks++;
    if (bad_pulse != 0) begin
      failures++;
      $display("FAIL pulse_shape: %0d long or overlapping error pulses, expected 0", bad_pulse);
    end else $display("ok   pulse_shape");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
